// File: rtl/puzzle_draw_pkg.sv
// rtl/puzzle_draw_pkg.sv - shared states, board geometry and tile-origin helpers for the tile draw scheduler
package puzzle_draw_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_GPREP,
    S_GLYPH,
    S_NEXT,
    S_FIN
  } state_t;

  localparam int TILE_PITCH           = 30;
  localparam int BOARD_X0             = 20;
  localparam int BOARD_Y0             = 0;
  localparam int GLYPH_CYCLES_DEFAULT = 111;

  function automatic logic [7:0] origin_x(input logic [3:0] idx);
    return 8'(BOARD_X0 + TILE_PITCH * int'(idx[1:0]));
  endfunction

  function automatic logic [6:0] origin_y(input logic [3:0] idx);
    return 7'(BOARD_Y0 + TILE_PITCH * int'(idx[3:2]));
  endfunction

endpackage

// File: rtl/tile_draw_scheduler_if.sv
// rtl/tile_draw_scheduler_if.sv - request, glyph-drawer and pixel-write signals of the tile draw scheduler
interface tile_draw_scheduler_if;
  logic        start;
  logic [63:0] board;
  logic [7:0]  glyph_x;
  logic [6:0]  glyph_y;
  logic [7:0]  tile_x;
  logic [6:0]  tile_y;
  logic [3:0]  glyph_sel;
  logic        glyph_en;
  logic        glyph_resetn;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  modport master (
    output start, board, glyph_x, glyph_y,
    input  tile_x, tile_y, glyph_sel, glyph_en, glyph_resetn,
    input  x_out, y_out, colour, plot, busy, done
  );

  modport slave (
    input  start, board, glyph_x, glyph_y,
    output tile_x, tile_y, glyph_sel, glyph_en, glyph_resetn,
    output x_out, y_out, colour, plot, busy, done
  );
endinterface

// File: rtl/tile_scan_counter.sv
// rtl/tile_scan_counter.sv - 30x30 raster counter (cx fastest) with a flag on the final pixel
module tile_scan_counter
  import puzzle_draw_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       en,
  output logic [4:0] cx,
  output logic [4:0] cy,
  output logic       last
);
  localparam logic [4:0] MAXC = 5'(TILE_PITCH - 1);

  assign last = (cx == MAXC) && (cy == MAXC);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clr) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (cx == MAXC) begin
        cx <= '0;
        cy <= (cy == MAXC) ? 5'd0 : cy + 5'd1;
      end else begin
        cx <= cx + 5'd1;
      end
    end
  end
endmodule

// File: rtl/tile_draw_scheduler.sv
// rtl/tile_draw_scheduler.sv - clears and redraws the 4x4 board tile by tile through an external glyph drawer
// Optional DIRTY_ONLY_EN: skip tiles unchanged since the last completed redraw.
module tile_draw_scheduler
  import puzzle_draw_pkg::*;
#(
  parameter logic [2:0] BG_COLOUR    = 3'b000,
  parameter logic [2:0] FG_COLOUR    = 3'b111,
  parameter int         GLYPH_CYCLES = GLYPH_CYCLES_DEFAULT
) (
  input logic                  clk,
  input logic                  resetn,
  tile_draw_scheduler_if.slave bus
);
  localparam int GW = $clog2(GLYPH_CYCLES);

  state_t        state, state_n;
  logic [3:0]    idx, idx_inc;
  logic [63:0]   board_q;
  logic [7:0]    tile_x;
  logic [6:0]    tile_y;
  logic [3:0]    glyph_sel;
  logic [GW-1:0] gcnt;
  logic [4:0]    cx, cy;
  logic          scan_last;
  logic          first_clean, next_clean;
  logic [7:0]    x_out;
  logic [6:0]    y_out;
  logic [2:0]    colour;
  logic          plot, glyph_en, glyph_resetn;

  assign idx_inc = idx + 4'd1;

  tile_scan_counter u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state == S_LOAD),
    .en     (state == S_CLEAR),
    .cx     (cx),
    .cy     (cy),
    .last   (scan_last)
  );

`ifdef DIRTY_ONLY_EN
  logic [63:0] shadow;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      shadow <= '0;
    else if (state == S_FIN)
      shadow <= board_q;
  end

  // Tile 0 is judged from the live board because the latch happens in the same cycle.
  assign first_clean = (bus.board[3:0] == shadow[3:0]);
  assign next_clean  = (board_q[{idx_inc, 2'b00} +: 4] == shadow[{idx_inc, 2'b00} +: 4]);
`else
  assign first_clean = 1'b0;
  assign next_clean  = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      idx       <= '0;
      board_q   <= '0;
      tile_x    <= '0;
      tile_y    <= '0;
      glyph_sel <= '0;
      gcnt      <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (bus.start) begin
          board_q <= bus.board;
          idx     <= '0;
        end
        S_LOAD: begin
          tile_x    <= origin_x(idx);
          tile_y    <= origin_y(idx);
          glyph_sel <= board_q[{idx, 2'b00} +: 4];
        end
        S_GPREP: gcnt <= '0;
        S_GLYPH: gcnt <= gcnt + 1'b1;
        S_NEXT:  if (idx != 4'd15) idx <= idx_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n      = state;
    x_out        = '0;
    y_out        = '0;
    colour       = '0;
    plot         = 1'b0;
    glyph_en     = 1'b0;
    glyph_resetn = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_n = first_clean ? S_NEXT : S_LOAD;
      S_LOAD:  state_n = S_CLEAR;
      S_CLEAR: begin
        x_out  = tile_x + {3'b000, cx};
        y_out  = tile_y + {2'b00, cy};
        colour = BG_COLOUR;
        plot   = 1'b1;
        if (scan_last) state_n = (glyph_sel == 4'd0) ? S_NEXT : S_GPREP;
      end
      S_GPREP: state_n = S_GLYPH;
      S_GLYPH: begin
        x_out        = bus.glyph_x;
        y_out        = bus.glyph_y;
        colour       = FG_COLOUR;
        plot         = 1'b1;
        glyph_en     = 1'b1;
        glyph_resetn = 1'b1;
        if (gcnt == GW'(GLYPH_CYCLES - 1)) state_n = S_NEXT;
      end
      S_NEXT: begin
        if (idx == 4'd15)    state_n = S_FIN;
        else if (next_clean) state_n = S_NEXT;
        else                 state_n = S_LOAD;
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.tile_x       = tile_x;
  assign bus.tile_y       = tile_y;
  assign bus.glyph_sel    = glyph_sel;
  assign bus.glyph_en     = glyph_en;
  assign bus.glyph_resetn = glyph_resetn;
  assign bus.x_out        = x_out;
  assign bus.y_out        = y_out;
  assign bus.colour       = colour;
  assign bus.plot         = plot;
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = (state == S_FIN);
endmodule

// File: tb/tb_tile_draw_scheduler.sv
// tb/tb_tile_draw_scheduler.sv - self-checking bench for tile_draw_scheduler (DIRTY_ONLY_EN aware)
module tb_tile_draw_scheduler;
  logic clk = 1'b0;
  logic resetn = 1'b0;

  tile_draw_scheduler_if bus();

  tile_draw_scheduler dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t        exp_q[$];
  int          gtile_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc, exp_lat, done_cyc, done_cnt, busy_cnt, bg_cnt, fg_cnt;
  int          pix_err, en_err, gl_err, run_len, cur_tile;
  logic        pre_ok, prev_gres, prev_plot;
  logic [7:0]  gx, g_tx;
  logic [6:0]  gy, g_ty;
  logic [3:0]  g_sel;
  logic [63:0] cur_board, tb_shadow, b;
  pix_t        t15_first, last_bg;

  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected pixel stream and latency derived from the board rules, not from the FSM.
  task automatic build_model(input logic [63:0] bd);
    pix_t p;
    bit   clean;
    exp_q.delete();
    gtile_q.delete();
    exp_lat = 2;
    for (int t = 0; t < 16; t++) begin
      clean = 1'b0;
`ifdef DIRTY_ONLY_EN
      clean = (bd[4*t +: 4] == tb_shadow[4*t +: 4]);
`endif
      if (clean) begin
        exp_lat += 1;
      end else begin
        exp_lat += 902;
        for (int y = 0; y < 30; y++)
          for (int x = 0; x < 30; x++) begin
            p.x = 8'(20 + 30 * (t % 4) + x);
            p.y = 7'(30 * (t / 4) + y);
            p.c = 3'b000;
            exp_q.push_back(p);
          end
        if (bd[4*t +: 4] != 4'd0) begin
          exp_lat += 112;
          p.x = gx; p.y = gy; p.c = 3'b111;
          for (int k = 0; k < 111; k++) exp_q.push_back(p);
          gtile_q.push_back(t);
        end
      end
    end
  endtask

  task automatic reset_stats();
    cyc = 1; done_cyc = 0; done_cnt = 0; busy_cnt = 0; bg_cnt = 0; fg_cnt = 0;
    pix_err = 0; en_err = 0; gl_err = 0; run_len = 0; cur_tile = -1;
    pre_ok = 1'b1; prev_gres = 1'b0; prev_plot = 1'b0;
  endtask

  task automatic sample();
    pix_t p;
    @(negedge clk);
    cyc++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (bus.glyph_en !== bus.glyph_resetn) en_err++;
    if (bus.plot === 1'b1) begin
      p = {bus.x_out, bus.y_out, bus.colour};
      if (p.c == 3'b000) begin
        bg_cnt++;
        if (bg_cnt == 13501) t15_first = p;
        last_bg = p;
      end else fg_cnt++;
      if (exp_q.size() == 0) pix_err++;
      else if (exp_q.pop_front() !== p) pix_err++;
    end
    if (bus.glyph_en === 1'b1) begin
      if (run_len == 0) begin
        if (gtile_q.size() == 0) begin gl_err++; cur_tile = -1; end
        else cur_tile = gtile_q.pop_front();
        g_tx = bus.tile_x; g_ty = bus.tile_y; g_sel = bus.glyph_sel;
        if (!(prev_gres === 1'b0 && prev_plot === 1'b0)) pre_ok = 1'b0;
      end
      run_len++;
      if (cur_tile >= 0 && (bus.tile_x !== 8'(20 + 30 * (cur_tile % 4)) ||
          bus.tile_y !== 7'(30 * (cur_tile / 4)) || bus.glyph_sel !== cur_board[4*cur_tile +: 4]))
        gl_err++;
    end else if (run_len != 0) begin
      if (run_len != 111) gl_err++;
      run_len = 0;
    end
    prev_gres = bus.glyph_resetn;
    prev_plot = bus.plot;
  endtask

  task automatic run_frame(input logic [63:0] bd, input int restart_at);
    int guard;
    gx = 8'($urandom);
    gy = 7'($urandom);
    bus.glyph_x = gx;
    bus.glyph_y = gy;
    cur_board = bd;
    build_model(bd);
    reset_stats();
    bus.start = 1'b1;
    bus.board = bd;
    guard = 0;
    while (done_cnt == 0 && guard < 20000) begin
      sample();
      guard++;
      bus.start = (cyc == restart_at);
      bus.board = {$urandom, $urandom};
    end
    sample();
    chk("done_latency", done_cyc, exp_lat);
    chk("done_pulses", done_cnt, 1);
    chk("idle_after_fin", bus.busy, 0);
    chk("busy_cycles", busy_cnt, exp_lat - 1);
    chk("pixel_errors", pix_err, 0);
    chk("pixels_missing", exp_q.size(), 0);
    chk("glyph_errors", gl_err, 0);
    chk("glyphs_missing", gtile_q.size(), 0);
    chk("en_vs_resetn", en_err, 0);
    chk("gprep_before_glyph", pre_ok, 1);
`ifdef DIRTY_ONLY_EN
    tb_shadow = bd;
`endif
  endtask

  initial begin
    int guard;
    bus.start = 1'b0;
    bus.board = '0;
    bus.glyph_x = '0;
    bus.glyph_y = '0;
    tb_shadow = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.plot, bus.busy, bus.done, bus.glyph_en, bus.glyph_resetn, bus.x_out,
        bus.y_out, bus.tile_x, bus.tile_y, bus.glyph_sel, bus.colour}, 0);
    resetn = 1'b1;
    @(negedge clk);

    run_frame(64'd0, 0);
    chk("blank_board_fg", fg_cnt, 0);
`ifndef DIRTY_ONLY_EN
    chk("tile15_first_px", t15_first, {8'd110, 7'd90, 3'b000});
    chk("tile15_last_px", last_bg, {8'd139, 7'd119, 3'b000});
`endif

    b = 64'd0;
    b[23:20] = 4'd6;
    run_frame(b, 0);
    chk("tile5_x", g_tx, 50);
    chk("tile5_y", g_ty, 30);
    chk("tile5_sel", g_sel, 6);
    chk("tile5_fg", fg_cnt, 111);

    run_frame({$urandom, $urandom}, 3000);

    b = {$urandom, $urandom};
    b[31:28] = 4'(1 + $urandom_range(0, 14));
    cur_board = b;
    gx = 8'($urandom); gy = 7'($urandom);
    bus.glyph_x = gx; bus.glyph_y = gy;
    build_model(b);
    reset_stats();
    bus.start = 1'b1;
    bus.board = b;
    guard = 0;
    while (!(cur_tile == 7 && run_len == 40) && guard < 20000) begin
      sample();
      guard++;
      bus.start = 1'b0;
      bus.board = {$urandom, $urandom};
    end
    chk("reached_tile7_glyph", cur_tile, 7);
    #2 resetn = 1'b0;
    tb_shadow = '0;
    #1 chk("outputs_in_reset", {bus.plot, bus.busy, bus.done, bus.glyph_en, bus.glyph_resetn,
        bus.x_out, bus.y_out, bus.tile_x, bus.tile_y, bus.glyph_sel, bus.colour}, 0);
    repeat (3) sample();
    resetn = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    repeat (20) sample();
    chk("no_done_after_abort", done_cnt, 0);
    chk("idle_after_abort", busy_cnt, 0);

    b = {$urandom, $urandom};
    run_frame(b, 0);
`ifdef DIRTY_ONLY_EN
    run_frame(b, 0);
    chk("repeat_no_plot", bg_cnt + fg_cnt, 0);
    chk("repeat_latency", done_cyc, 18);
    b[15:12] = b[15:12] + 4'd1;
    run_frame(b, 0);
    chk("dirty_tile3_clear", bg_cnt, 900);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tile_draw_scheduler.md
TILE_DRAW_SCHEDULER -- requirements
Module: tile_draw_scheduler

Interface
REQ-001 Parameter: BG_COLOUR, 3'b000, colour driven during tile clear.
REQ-002 Parameter: FG_COLOUR, 3'b111, colour driven during glyph draw.
REQ-003 Parameter: GLYPH_CYCLES, 111, cycles one number drawer needs per full glyph (counter 0..110).
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: resetn  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  one-cycle request to redraw the board.
REQ-007 Port: board  input  64  sixteen 4-bit tile values, tile i = board[4i+3:4i]; row-major, 0 = blank.
REQ-008 Port: glyph_x / glyph_y  input  8 / 7  absolute pixel from the selected number drawer.
REQ-009 Port: tile_x / tile_y  output  8 / 7  origin of the current tile, fed to the drawer's xIn/yIn.
REQ-010 Port: glyph_sel  output  4  tile value selecting the drawer.
REQ-011 Port: glyph_en / glyph_resetn  output  1 / 1  drawer enable and drawer active-low reset.
REQ-012 Port: x_out / y_out / colour / plot  output  8 / 7 / 3 / 1  pixel write to the VGA adapter.
REQ-013 Port: busy / done  output  1 / 1  redraw in progress; one-cycle completion pulse.

Function
REQ-014 States SHALL be IDLE, LOAD, CLEAR, GPREP, GLYPH, NEXT, FIN.
REQ-015 IDLE: on start=1, board SHALL be latched and the FSM SHALL enter LOAD with tile index 0.
REQ-016 start SHALL be ignored in every state except IDLE; board changes after latching SHALL have no effect.
REQ-017 Tile origin SHALL be tile_x = 20 + 30*col, tile_y = 30*row, where col = idx[1:0] and row = idx[3:2].
REQ-018 LOAD SHALL last one cycle and reset the 5-bit clear counters cx and cy to 0.
REQ-019 CLEAR SHALL plot a 30x30 block: x_out = tile_x+cx, y_out = tile_y+cy, colour = BG_COLOUR, plot = 1; cx SHALL wrap 29->0 and increment cy; the state SHALL exit after (29,29), taking exactly 900 cycles.
REQ-020 After CLEAR, a tile value of 0 SHALL go to NEXT; any other value SHALL go to GPREP.
REQ-021 GPREP SHALL last one cycle with glyph_resetn = 0, so the synchronous drawer counter restarts at 0.
REQ-022 GLYPH SHALL hold glyph_en = 1 and glyph_resetn = 1 for exactly GLYPH_CYCLES cycles, with x_out/y_out = glyph_x/glyph_y, colour = FG_COLOUR, plot = 1.
REQ-023 glyph_resetn SHALL be 0 in every state except GLYPH; glyph_en SHALL be 0 outside GLYPH.
REQ-024 NEXT SHALL go to LOAD with idx+1 when idx < 15, and to FIN when idx = 15; plot SHALL be 0 in NEXT.
REQ-025 FIN SHALL pulse done = 1 for one cycle and then return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 A full redraw of k non-blank tiles SHALL take 1 + 16*(1+900+1) + k*(1+GLYPH_CYCLES) + 1 cycles from start to done.

Reset
REQ-028 On resetn = 0, asynchronously and from any state: state = IDLE, idx/cx/cy/latched board = 0, plot/busy/done/glyph_en = 0, glyph_resetn = 0, x_out/y_out/tile_x/tile_y/glyph_sel = 0, colour = 0.
REQ-029 Reset mid-redraw SHALL abandon the frame with no done pulse.

Configuration
REQ-030 Macro DIRTY_ONLY_EN defined: a 64-bit shadow of the last drawn board (reset 0) SHALL be kept, tiles whose value equals the shadow SHALL skip LOAD/CLEAR/GLYPH, going straight to NEXT, and the shadow SHALL update at FIN.
REQ-031 Macro DIRTY_ONLY_EN undefined: every tile SHALL be redrawn on every start, and no shadow register SHALL exist.

Structure
REQ-032 Package puzzle_draw_pkg SHALL hold the state enum, TILE_PITCH=30, BOARD_X0=20, BOARD_Y0=0 and the default GLYPH_CYCLES.
REQ-033 One sub-module, tile_scan_counter (cx/cy 30x30 raster with last flag), SHALL be used; glyph drawers SHALL remain external.

Verification
REQ-034 Reset, then start with board = 0: 16 clears only; done at cycle 1+16*902+1 = 14434; plot never FG_COLOUR.
REQ-035 Tile 5 = 6, others 0: in GLYPH, tile_x = 50 and tile_y = 30, glyph_sel = 6, glyph_en high exactly 111 cycles, preceded by one glyph_resetn-low cycle.
REQ-036 start pulsed again while busy: ignored, a single done pulse.
REQ-037 resetn dropped during tile 7 GLYPH: outputs zero immediately, no done pulse; a later start redraws from tile 0.
REQ-038 DIRTY_ONLY_EN: two identical starts: the second produces no plot and gives done 17 cycles after start; changing only tile 3 redraws only tile 3.
REQ-039 Corner check: first CLEAR pixel of tile 15 is (110,90) and last is (139,119).
